// File: rtl/jk_bank_pkg.sv
// Shared types and the JK next-state helper for the jk_bank_arb slice.
// Latency: combinational helper only; no state.
// Backpressure: not applicable.
//
// Contents: jk_op_t ({J,K} op encoding) and jk_next(q, op).
package jk_bank_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_t;

   // Next value of one JK cell given its current value and the op.
   function automatic logic jk_next(input logic q, input jk_op_t op);
      logic r;
      case (op)
         JK_HOLD:   r = q;
         JK_RESET:  r = 1'b0;
         JK_SET:    r = 1'b1;
         JK_TOGGLE: r = ~q;
         default:   r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_rr_arb.sv
// Round-robin arbiter with optional grant lock (macro JK_BANK_ARB_LOCK_EN).
// Latency: grant is combinational from req_val in the same cycle.
// Backpressure: losers see grant=0 and must hold req_val until granted.
//
// Ports:
//   clk, reset_n    clock, async active-low reset (grant forced to 0 in reset)
//   req_val[NREQ]   request vector
//   req_lock[NREQ]  lock request (only with JK_BANK_ARB_LOCK_EN)
//   grant[NREQ]     one-hot or zero winner
//   grant_id        winner index, valid when grant_any=1
//   grant_any       a request is being accepted this cycle
module jk_rr_arb #(
   parameter int NREQ = 4,
`ifdef JK_BANK_ARB_LOCK_EN
   parameter int MAX_LOCK = 4,
`endif
   localparam int IDW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req_val,
`ifdef JK_BANK_ARB_LOCK_EN
   input  logic [NREQ-1:0] req_lock,
`endif
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            grant_any
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] eff_ptr;
   logic           found;
   int             cand;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] x);
      logic [IDW-1:0] r;
      if (int'(x) == NREQ - 1) r = '0;
      else                     r = x + 1'b1;
      return r;
   endfunction

`ifdef JK_BANK_ARB_LOCK_EN
   localparam int CW = $clog2(MAX_LOCK + 1);

   logic           lock_act;
   logic [IDW-1:0] lock_id;
   logic [CW-1:0]  lock_cnt;
   logic           lock_hold;

   // Lock survives only while the owner keeps both valid and lock high.
   assign lock_hold = lock_act & req_val[lock_id] & req_lock[lock_id];
   // The pointer stays parked during a lock; a release resumes the search
   // just past the lock owner.
   assign eff_ptr   = lock_act ? next_id(lock_id) : ptr;
`else
   assign eff_ptr   = ptr;
`endif

   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      cand     = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(eff_ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!found && req_val[cand]) begin
            found    = 1'b1;
            grant_id = cand[IDW-1:0];
         end
      end
`ifdef JK_BANK_ARB_LOCK_EN
      if (lock_hold) begin
         found    = 1'b1;
         grant_id = lock_id;
      end
`endif
   end

   // Nothing may be accepted while reset is asserted.
   assign grant_any = found & reset_n;

   always_comb begin
      grant = '0;
      if (grant_any) grant[grant_id] = 1'b1;
   end

`ifdef JK_BANK_ARB_LOCK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr      <= '0;
         lock_act <= 1'b0;
         lock_id  <= '0;
         lock_cnt <= '0;
      end else if (lock_hold) begin
         // lock_cnt counts grants already given inside this lock.
         if (lock_cnt == CW'(MAX_LOCK - 1)) begin
            lock_act <= 1'b0;
            lock_cnt <= '0;
            ptr      <= next_id(lock_id);
         end else begin
            lock_cnt <= lock_cnt + 1'b1;
         end
      end else begin
         lock_act <= 1'b0;
         lock_cnt <= '0;
         if (grant_any) begin
            if (req_lock[grant_id] && (MAX_LOCK > 1)) begin
               lock_act <= 1'b1;
               lock_id  <= grant_id;
               lock_cnt <= CW'(1);
               ptr      <= eff_ptr;
            end else begin
               ptr <= next_id(grant_id);
            end
         end else begin
            ptr <= eff_ptr;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= next_id(grant_id);
      end
   end
`endif

endmodule

// File: rtl/jk_bank_arb.sv
// Bank of NBITS JK cells shared by NREQ requesters via round-robin arbitration.
// Latency: accepted op updates q at the accepting edge; response is registered
//          at the same edge (valid the following cycle). Optional lock: JK_BANK_ARB_LOCK_EN.
// Backpressure: one command per cycle; req_rdy is combinational from req_val.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req_val/req_rdy[NREQ] per-requester handshake
//   req_idx[NREQ*IW]      cell index, requester i in slice i
//   req_op[NREQ*2]        {J,K} op, requester i in slice i
//   req_lock[NREQ]        lock request (only with JK_BANK_ARB_LOCK_EN)
//   q[NBITS]              cell values
//   resp_val/resp_id/resp_q  registered completion report
module jk_bank_arb
   import jk_bank_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
`ifdef JK_BANK_ARB_LOCK_EN
   parameter int MAX_LOCK = 4,
`endif
   localparam int IW  = $clog2(NBITS),
   localparam int IDW = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req_val,
   output logic [NREQ-1:0]    req_rdy,
   input  logic [NREQ*IW-1:0] req_idx,
   input  logic [NREQ*2-1:0]  req_op,
`ifdef JK_BANK_ARB_LOCK_EN
   input  logic [NREQ-1:0]    req_lock,
`endif
   output logic [NBITS-1:0]   q,
   output logic               resp_val,
   output logic [IDW-1:0]     resp_id,
   output logic               resp_q
);

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            grant_any;
   logic [IW-1:0]   sel_idx;
   jk_op_t          sel_op;
   logic            cell_new;

   jk_rr_arb #(
      .NREQ(NREQ)
`ifdef JK_BANK_ARB_LOCK_EN
      , .MAX_LOCK(MAX_LOCK)
`endif
   ) u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_val   (req_val),
`ifdef JK_BANK_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   assign req_rdy = grant;

   // Mux the winner's command and compute the addressed cell's next value.
   always_comb begin
      sel_idx  = req_idx[int'(grant_id)*IW +: IW];
      sel_op   = jk_op_t'(req_op[int'(grant_id)*2 +: 2]);
      cell_new = jk_next(q[sel_idx], sel_op);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q        <= '0;
         resp_val <= 1'b0;
         resp_id  <= '0;
         resp_q   <= 1'b0;
      end else begin
         resp_val <= grant_any;
         if (grant_any) begin
            q[sel_idx] <= cell_new;
            resp_id    <= grant_id;
            resp_q     <= cell_new;
         end
      end
   end

endmodule
